// File: rtl/poisson_spike_gen_if.sv
// poisson_spike_gen_if: step/rate control, generator link and spike event handshake of the Poisson spike source
interface poisson_spike_gen_if #(
  parameter int N = 32,
  parameter int REFRAC_W = 8,
  parameter int CNT_W = 16
);
  logic en;
  logic step;
  logic [N-1:0] rate;
  logic [REFRAC_W-1:0] refrac_steps;
  logic [N-1:0] pn_num;
  logic pn_next;
  logic spike_valid;
  logic spike_ready;
  logic [CNT_W-1:0] spike_count;
  logic overflow;
  logic step_missed;
  logic busy;
  modport master (
    output en, step, rate, refrac_steps, pn_num, spike_ready,
    input  pn_next, spike_valid, spike_count, overflow, step_missed, busy
  );
  modport slave (
    input  en, step, rate, refrac_steps, pn_num, spike_ready,
    output pn_next, spike_valid, spike_count, overflow, step_missed, busy
  );
endinterface

// File: rtl/poisson_spike_gen.sv
// poisson_spike_gen: timestep-driven Poisson spike source with refractory period, saturating count and sticky error flags
module poisson_spike_gen #(
  parameter int N = 32,
  parameter int REFRAC_W = 8,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  poisson_spike_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRAW, COMPARE} state_t;
  state_t state;
  logic [REFRAC_W-1:0] refrac_cnt;
  logic [CNT_W-1:0] count;
  logic go, draw, spike;
  always_comb begin
    go = bus.en & bus.step;
    draw = state == IDLE && go && refrac_cnt == '0;
    spike = state == COMPARE && N'(bus.pn_num) < N'(bus.rate);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      refrac_cnt <= '0;
      count <= '0;
      bus.pn_next <= 1'b0;
      bus.spike_valid <= 1'b0;
      bus.overflow <= 1'b0;
      bus.step_missed <= 1'b0;
    end else begin
      state <= draw ? DRAW : state == DRAW ? COMPARE : IDLE;
      bus.pn_next <= draw;
      // steps landing during the refractory window are consumed without a draw
      refrac_cnt <= spike ? bus.refrac_steps :
                    (state == IDLE && go && refrac_cnt != '0) ? refrac_cnt - 1'b1 : refrac_cnt;
      count <= (spike && ~&count) ? count + 1'b1 : count;
      bus.spike_valid <= spike | (bus.spike_valid & ~bus.spike_ready);
      bus.overflow <= bus.overflow | (spike & bus.spike_valid & ~bus.spike_ready);
      bus.step_missed <= bus.step_missed | (state != IDLE && go);
    end
  end
  assign bus.spike_count = count;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_poisson_spike_gen.sv
// tb_poisson_spike_gen: random and directed steps against a step-level reference model, two counter widths
module tb_poisson_spike_gen;
  logic clk = 1'b0;
  logic rst;
  int n_vec = 0;
  int n_bad = 0;
  int m_refrac = 0;
  int m_total = 0;
  bit m_pending = 0;
  bit m_ovf = 0;
  bit m_missed = 0;

  always #5 clk = ~clk;

  poisson_spike_gen_if #(.N(32), .REFRAC_W(8), .CNT_W(16)) b();
  poisson_spike_gen_if #(.N(32), .REFRAC_W(8), .CNT_W(4)) s();

  assign s.en = b.en;
  assign s.step = b.step;
  assign s.rate = b.rate;
  assign s.refrac_steps = b.refrac_steps;
  assign s.pn_num = b.pn_num;
  assign s.spike_ready = b.spike_ready;

  poisson_spike_gen #(.N(32), .REFRAC_W(8), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(b));
  poisson_spike_gen #(.N(32), .REFRAC_W(8), .CNT_W(4)) dut_sat (.clk(clk), .rst(rst), .bus(s));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int t, input int mx);
    return t > mx ? mx : t;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_valid"}, 64'(b.spike_valid), 64'(m_pending));
    check({tag, "_count"}, 64'(b.spike_count), 64'(sat(m_total, 65535)));
    check({tag, "_count4"}, 64'(s.spike_count), 64'(sat(m_total, 15)));
    check({tag, "_ovf"}, 64'(b.overflow), 64'(m_ovf));
    check({tag, "_missed"}, 64'(b.step_missed), 64'(m_missed));
    check({tag, "_busy"}, 64'(b.busy), 64'(0));
    check({tag, "_pn_next"}, 64'(b.pn_next), 64'(0));
  endtask

  task automatic run_step(input bit e, input logic [31:0] r, input logic [31:0] v,
                          input bit rdy, input logic [7:0] rs, input bit dbl);
    bit draw, spike, prev;
    b.en = e;
    b.step = 1'b1;
    b.rate = r;
    b.spike_ready = rdy;
    b.refrac_steps = rs;
    b.pn_num = $urandom;
    draw = e && m_refrac == 0;
    if (e && m_refrac > 0) m_refrac--;
    prev = m_pending && !rdy;
    @(negedge clk);
    if (!dbl) b.step = 1'b0;
    check("pn_next_t1", 64'(b.pn_next), 64'(draw));
    check("busy_t1", 64'(s.busy), 64'(draw));
    @(negedge clk);
    b.step = 1'b0;
    if (draw) b.pn_num = v;
    if (dbl && draw) m_missed = 1;
    check("pn_next_t2", 64'(b.pn_next), 64'(0));
    @(negedge clk);
    spike = draw && v < r;
    if (spike) begin
      m_total++;
      m_refrac = int'(rs);
      if (prev) m_ovf = 1;
    end
    m_pending = spike || prev;
    check_state("step");
    @(negedge clk);
    if (rdy) m_pending = 0;
    check("valid_after", 64'(b.spike_valid), 64'(m_pending));
  endtask

  task automatic reset_mid_draw();
    while (m_refrac != 0) run_step(1'b1, 32'h0, 32'h0, 1'b1, 8'd0, 1'b0);
    b.en = 1'b1;
    b.step = 1'b1;
    b.spike_ready = 1'b0;
    @(negedge clk);
    b.step = 1'b0;
    check("rst_draw_pn_next", 64'(b.pn_next), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_refrac = 0; m_total = 0; m_pending = 0; m_ovf = 0; m_missed = 0;
    check_state("rst_mid");
    rst = 1'b0;
    b.pn_num = 32'h0;
    b.rate = 32'hFFFF_FFFF;
    @(negedge clk);
    check("rst_after_pn_next", 64'(b.pn_next), 64'(0));
    check("rst_after_busy", 64'(b.busy), 64'(0));
    @(negedge clk);
    check("rst_after_valid", 64'(b.spike_valid), 64'(0));
  endtask

  initial begin
    bit e, dbl;
    logic [31:0] r, v;
    rst = 1'b1;
    b.en = 1'b0;
    b.step = 1'b0;
    b.rate = '0;
    b.refrac_steps = '0;
    b.pn_num = '0;
    b.spike_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_state("reset");
    rst = 1'b0;
    @(negedge clk);
    run_step(1'b1, 32'h8000_0000, 32'h1234_5678, 1'b1, 8'd0, 1'b0);
    run_step(1'b1, 32'h8000_0000, 32'h9000_0000, 1'b1, 8'd0, 1'b0);
    run_step(1'b1, 32'h0, 32'h0000_0001, 1'b1, 8'd0, 1'b0);
    run_step(1'b1, 32'h0, 32'h0, 1'b1, 8'd0, 1'b0);
    run_step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 8'd0, 1'b0);
    run_step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 8'd0, 1'b0);
    run_step(1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, 8'd0, 1'b0);
    run_step(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 8'd3, 1'b0);
    repeat (4) run_step(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 8'd0, 1'b0);
    run_step(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, 8'd0, 1'b0);
    run_step(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 8'd0, 1'b0);
    b.spike_ready = 1'b1;
    @(negedge clk);
    m_pending = 0;
    check("bp_drain", 64'(b.spike_valid), 64'(m_pending));
    run_step(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 8'd0, 1'b1);
    for (int i = 0; i < 150; i++) begin
      e = $urandom_range(0, 7) != 0;
      case ($urandom_range(0, 3))
        0: r = 32'h0;
        1: r = 32'hFFFF_FFFF;
        default: r = $urandom;
      endcase
      v = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
      dbl = e && m_refrac == 0 && $urandom_range(0, 4) == 0;
      run_step(e, r, v, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 2)), dbl);
    end
    check("sat_count4", 64'(s.spike_count), 64'(sat(m_total, 15)));
    reset_mid_draw();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
